// File: rtl/demux_1to4_buf.sv
//==============================================================================
// Module   : demux_1to4_buf
// Brief    : 1-to-4 demultiplexer with an independent 2-entry FIFO per channel.
//            Optional macro DEMUX_RR_EN selects the target channel from an
//            internal round-robin pointer instead of sel.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif

module demux_1to4_buf #(
    parameter int DATA_W = `INTERNAL_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Data_in,
    input  logic [1:0]        sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] Data_out1,
    output logic [DATA_W-1:0] Data_out2,
    output logic [DATA_W-1:0] Data_out3,
    output logic [DATA_W-1:0] Data_out4,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic              busy
);

    logic [1:0]        w_tgt;
    logic              w_push_any;
    logic [3:0]        w_push;
    logic [3:0]        w_pop;
    logic [3:0]        w_full;
    logic [DATA_W-1:0] w_head [4];

`ifdef DEMUX_RR_EN
    logic [1:0] r_rr_ptr;

    // Pointer moves only on an accepted word so a stalled producer retries the same channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 2'd0;
        end else if (w_push_any) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end
    end

    assign w_tgt = r_rr_ptr;
`else
    assign w_tgt = sel;
`endif

    // Ready looks only at occupancy, never at out_ready, so a full channel blocks even while popping.
    assign in_ready   = ~w_full[w_tgt];
    assign w_push_any = in_valid & in_ready;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_ch
            logic [DATA_W-1:0] r_mem [2];
            logic [1:0]        r_cnt;
            logic              r_rd_ptr;
            logic              r_wr_ptr;

            assign w_push[g]    = w_push_any && (w_tgt == 2'(g));
            assign out_valid[g] = (r_cnt != 2'd0);
            assign w_pop[g]     = out_valid[g] & out_ready[g];
            assign w_full[g]    = (r_cnt == 2'd2);
            assign w_head[g]    = out_valid[g] ? r_mem[r_rd_ptr] : '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt    <= 2'd0;
                    r_rd_ptr <= 1'b0;
                    r_wr_ptr <= 1'b0;
                end else begin
                    if (w_push[g]) begin
                        r_mem[r_wr_ptr] <= Data_in;
                        r_wr_ptr        <= ~r_wr_ptr;
                    end
                    if (w_pop[g]) begin
                        r_rd_ptr <= ~r_rd_ptr;
                    end
                    case ({w_push[g], w_pop[g]})
                        2'b10:   r_cnt <= r_cnt + 2'd1;
                        2'b01:   r_cnt <= r_cnt - 2'd1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    endgenerate

    assign Data_out1 = w_head[0];
    assign Data_out2 = w_head[1];
    assign Data_out3 = w_head[2];
    assign Data_out4 = w_head[3];
    assign busy      = |out_valid;

endmodule

`default_nettype wire

// File: tb/tb_demux_1to4_buf.sv
//==============================================================================
// Module   : tb_demux_1to4_buf
// Brief    : Self-checking bench for demux_1to4_buf with a queue-based model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_demux_1to4_buf;

    logic        clk;
    logic        rst;
    logic [31:0] Data_in;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Data_out1;
    logic [31:0] Data_out2;
    logic [31:0] Data_out3;
    logic [31:0] Data_out4;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        busy;

    int n_pass;
    int n_total;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] q3[$];
    logic [1:0]  m_rr;

    demux_1to4_buf dut (
        .clk       (clk),
        .rst       (rst),
        .Data_in   (Data_in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Data_out1 (Data_out1),
        .Data_out2 (Data_out2),
        .Data_out3 (Data_out3),
        .Data_out4 (Data_out4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int qsz(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [31:0] qhead(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            2:       return q2[0];
            default: return q3[0];
        endcase
    endfunction

    function automatic logic [31:0] dout(input int i);
        case (i)
            0:       return Data_out1;
            1:       return Data_out2;
            2:       return Data_out3;
            default: return Data_out4;
        endcase
    endfunction

    // One clock: compare DUT against the model mid-cycle, then advance the model at the edge.
    task automatic step();
        logic [1:0]  tgt;
        logic        exp_rdy;
        logic [3:0]  ov;
        logic [31:0] exp_d;
        @(negedge clk);
`ifdef DEMUX_RR_EN
        tgt = m_rr;
`else
        tgt = sel;
`endif
        exp_rdy = (qsz(int'(tgt)) < 2);
        for (int i = 0; i < 4; i++) ov[i] = (qsz(i) > 0);
        if (!rst) begin
            chk("out_valid", {28'd0, out_valid}, {28'd0, ov});
            chk("busy", {31'd0, busy}, {31'd0, |ov});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            for (int i = 0; i < 4; i++) begin
                exp_d = ov[i] ? qhead(i) : 32'd0;
                chk($sformatf("data_out%0d", i + 1), dout(i), exp_d);
            end
        end
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete(); q3.delete();
            m_rr = 2'd0;
        end else begin
            if (ov[0] && out_ready[0]) void'(q0.pop_front());
            if (ov[1] && out_ready[1]) void'(q1.pop_front());
            if (ov[2] && out_ready[2]) void'(q2.pop_front());
            if (ov[3] && out_ready[3]) void'(q3.pop_front());
            if (in_valid && exp_rdy) begin
                case (tgt)
                    2'd0:    q0.push_back(Data_in);
                    2'd1:    q1.push_back(Data_in);
                    2'd2:    q2.push_back(Data_in);
                    default: q3.push_back(Data_in);
                endcase
                m_rr = m_rr + 2'd1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        m_rr      = 2'd0;
        rst       = 1'b1;
        Data_in   = 32'd0;
        sel       = 2'd0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;

        do_reset();
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
        step();

`ifndef DEMUX_RR_EN
        // Single push to channel 3.
        in_valid = 1'b1; sel = 2'd2; Data_in = 32'h11111111;
        step();
        in_valid = 1'b0;
        chk("push3_valid", {28'd0, out_valid}, 32'h4);
        chk("push3_data", Data_out3, 32'h11111111);
        chk("push3_busy", {31'd0, busy}, 32'd1);
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;

        // Fill channel 1, stall third word, pop once to unblock it.
        in_valid = 1'b1; sel = 2'd0; Data_in = 32'hA;
        step();
        Data_in = 32'hB;
        step();
        Data_in = 32'hC;
        chk("full_stall", {31'd0, in_ready}, 32'd0);
        step();
        out_ready = 4'b0001;
        step();
        out_ready = 4'b0000;
        chk("after_pop_head", Data_out1, 32'hB);
        chk("after_pop_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        out_ready = 4'b0001;
        step();
        step();
        out_ready = 4'b0000;

        // Simultaneous push and pop on channel 2 at count 1.
        in_valid = 1'b1; sel = 2'd1; Data_in = 32'h5;
        step();
        Data_in = 32'h6; out_ready = 4'b0010;
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("pushpop_data", Data_out2, 32'h6);
        chk("pushpop_valid", {28'd0, out_valid}, 32'h2);
        step();
        out_ready = 4'b0010;
        step();
        out_ready = 4'b0000;
`else
        // Round-robin order regardless of sel.
        out_ready = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; sel = 2'($urandom_range(0, 3)); Data_in = 32'(k);
            step();
        end
        in_valid = 1'b0;
        chk("rr_ch1", Data_out1, 32'h1);
        chk("rr_ch2", Data_out2, 32'h2);
        chk("rr_ch3", Data_out3, 32'h3);
        chk("rr_ch4", Data_out4, 32'h4);
        out_ready = 4'b0001;
        step();
        out_ready = 4'b0000;
        chk("rr_ch1_second", Data_out1, 32'h5);
        do_reset();
`endif

        // Randomised traffic with independent pushes and pops.
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            Data_in   = $urandom;
            out_ready = 4'($urandom_range(0, 15));
            step();
        end
        in_valid = 1'b0; out_ready = 4'b1111;
        step();
        step();
        out_ready = 4'b0000;

        // Fill every channel, then reset discards everything.
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; sel = 2'(k); Data_in = $urandom;
            step();
        end
        in_valid = 1'b0;
        chk("fill_valid", {28'd0, out_valid}, 32'hF);
        chk("fill_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; out_ready = 4'b1111; Data_in = 32'hDEADBEEF;
        do_reset();
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("rst_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_d1", Data_out1, 32'd0);
        chk("rst_d2", Data_out2, 32'd0);
        chk("rst_d3", Data_out3, 32'd0);
        chk("rst_d4", Data_out4, 32'd0);

        // Pops on empty channels are ignored.
        out_ready = 4'b1111;
        for (int k = 0; k < 10; k++) step();
        chk("empty_pop_valid", {28'd0, out_valid}, 32'd0);
        out_ready = 4'b0000;
        in_valid = 1'b1; sel = 2'd3; Data_in = 32'h77;
        step();
        in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
